// File: rtl/lock_entry_arbiter.sv
// Shares the fsm_password_lock digit/enter interface between a keypad (port 0) and a console
// (port 1). Optional saturating statistics counters are enabled by defining ARB_STATS_EN.
module lock_entry_arbiter #(
  parameter int unsigned DIGIT_GAP      = 1,
  parameter int unsigned RESP_TIMEOUT   = 16,
  parameter int unsigned LOCKOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [15:0] code0,
  input  logic        req1,
  input  logic [15:0] code1,
  output logic        done0,
  output logic        pass0,
  output logic        done1,
  output logic        pass1,
  output logic [3:0]  lock_digit,
  output logic        lock_enter,
  input  logic        lock_green,
  input  logic        lock_red,
  input  logic        lock_alarm,
  output logic        busy,
  output logic        locked_out
`ifdef ARB_STATS_EN
  ,
  output logic [7:0]  fail_count,
  output logic [7:0]  grant_count
`endif
);

  localparam int unsigned TmrW = $clog2(RESP_TIMEOUT + 1);
  localparam int unsigned LoW  = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(RESP_TIMEOUT - 1);
  localparam logic [LoW-1:0]  LoLast  = LoW'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]      GapLast = 4'(DIGIT_GAP);

  typedef enum logic [2:0] {StIdle, StSend, StWait, StResp, StLockout} state_e;

  state_e          state_q;
  logic            rr_q;
  logic            port_q;
  logic            alarm_q;
  logic [15:0]     shift_q;
  logic [1:0]      idx_q;
  logic [3:0]      slot_q;
  logic [TmrW-1:0] timer_q;
  logic [LoW-1:0]  lo_cnt_q;

  logic        grant_valid;
  logic        grant_port;
  logic [15:0] grant_code;
  logic        wait_done;
  logic        wait_pass;

  // rr_q names the favoured port when both requesters are pending.
  always_comb begin
    grant_port  = (req0 && (!req1 || !rr_q)) ? 1'b0 : 1'b1;
    grant_valid = (req0 || req1) && !locked_out;
    grant_code  = grant_port ? code1 : code0;
  end

  // Verdict priority: alarm, then red (beats green), then green, then timeout.
  always_comb begin
    wait_done = 1'b0;
    wait_pass = 1'b0;
    if (lock_alarm || lock_red) begin
      wait_done = 1'b1;
    end else if (lock_green) begin
      wait_done = 1'b1;
      wait_pass = 1'b1;
    end else if (timer_q == TmrLast) begin
      wait_done = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      rr_q       <= 1'b0;
      port_q     <= 1'b0;
      alarm_q    <= 1'b0;
      shift_q    <= '0;
      idx_q      <= '0;
      slot_q     <= '0;
      timer_q    <= '0;
      lo_cnt_q   <= '0;
      done0      <= 1'b0;
      pass0      <= 1'b0;
      done1      <= 1'b0;
      pass1      <= 1'b0;
      lock_digit <= '0;
      lock_enter <= 1'b0;
      busy       <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant_valid) begin
            state_q    <= StSend;
            port_q     <= grant_port;
            rr_q       <= ~grant_port;
            alarm_q    <= 1'b0;
            lock_digit <= grant_code[15:12];
            shift_q    <= {grant_code[11:0], 4'h0};
            lock_enter <= 1'b1;
            idx_q      <= '0;
            slot_q     <= '0;
            busy       <= 1'b1;
          end
        end
        StSend: begin
          if (slot_q == GapLast) begin
            if (idx_q == 2'd3) begin
              state_q <= StWait;
              timer_q <= '0;
            end else begin
              idx_q      <= idx_q + 2'd1;
              lock_digit <= shift_q[15:12];
              shift_q    <= {shift_q[11:0], 4'h0};
              lock_enter <= 1'b1;
              slot_q     <= '0;
            end
          end else begin
            slot_q     <= slot_q + 4'd1;
            lock_enter <= 1'b0;
          end
        end
        StWait: begin
          if (wait_done) begin
            state_q <= StResp;
            alarm_q <= lock_alarm;
            done0   <= ~port_q;
            done1   <= port_q;
            pass0   <= ~port_q & wait_pass;
            pass1   <= port_q & wait_pass;
          end else begin
            timer_q <= timer_q + TmrW'(1);
          end
        end
        StResp: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          pass0 <= 1'b0;
          pass1 <= 1'b0;
          if (alarm_q) begin
            state_q    <= StLockout;
            locked_out <= 1'b1;
            lo_cnt_q   <= '0;
          end else begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        StLockout: begin
          if (lo_cnt_q == LoLast) begin
            state_q    <= StIdle;
            locked_out <= 1'b0;
            busy       <= 1'b0;
          end else begin
            lo_cnt_q <= lo_cnt_q + LoW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic grant_fire;
  logic fail_fire;

  always_comb begin
    grant_fire = (state_q == StIdle) && grant_valid;
    fail_fire  = (state_q == StWait) && wait_done && !wait_pass;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fail_count  <= '0;
      grant_count <= '0;
    end else begin
      if (grant_fire && (grant_count != 8'hFF)) grant_count <= grant_count + 8'd1;
      if (fail_fire && (fail_count != 8'hFF))   fail_count  <= fail_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lock_entry_arbiter.sv
// Scoreboard bench for lock_entry_arbiter: requester drivers, a behavioural lock and a monitor
// that checks every done pulse against transactions queued in predicted service order.
module tb_lock_entry_arbiter;

  localparam int unsigned GAP  = 1;
  localparam int unsigned TMO  = 16;
  localparam int unsigned LOCK = 1000;
  localparam logic [15:0] SECRET = 16'h1234;

  typedef enum int {MNormal, MSilent, MAlarm, MBoth} mode_e;
  typedef struct {
    int          port;
    logic [15:0] code;
    mode_e       mode;
  } txn_t;

  logic        clk;
  logic        reset;
  logic        req0, req1;
  logic [15:0] code0, code1;
  logic        done0, pass0, done1, pass1;
  logic [3:0]  lock_digit;
  logic        lock_enter;
  logic        lock_green, lock_red, lock_alarm;
  logic        busy, locked_out;
`ifdef ARB_STATS_EN
  logic [7:0]  fail_count, grant_count;
`endif

  lock_entry_arbiter #(
    .DIGIT_GAP     (GAP),
    .RESP_TIMEOUT  (TMO),
    .LOCKOUT_CYCLES(LOCK)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .code0     (code0),
    .req1      (req1),
    .code1     (code1),
    .done0     (done0),
    .pass0     (pass0),
    .done1     (done1),
    .pass1     (pass1),
    .lock_digit(lock_digit),
    .lock_enter(lock_enter),
    .lock_green(lock_green),
    .lock_red  (lock_red),
    .lock_alarm(lock_alarm),
    .busy      (busy),
    .locked_out(locked_out)
`ifdef ARB_STATS_EN
    ,
    .fail_count (fail_count),
    .grant_count(grant_count)
`endif
  );

  txn_t        txn_q[$];
  logic [15:0] pq0[$];
  logic [15:0] pq1[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int favor = 0;
  int grants_exp = 0;
  int fails_exp = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit exp_pass(input txn_t t);
    return (t.mode == MNormal) && (t.code == SECRET);
  endfunction

  // Queue one transaction in service order; round robin then favours the other port.
  task automatic issue(input int p, input logic [15:0] code, input mode_e m);
    txn_t t;
    t.port = p;
    t.code = code;
    t.mode = m;
    txn_q.push_back(t);
    if (p == 0) pq0.push_back(code);
    else pq1.push_back(code);
    favor = 1 - p;
    grants_exp++;
    if (!exp_pass(t)) fails_exp++;
  endtask

  task automatic issue_both(input logic [15:0] c0, input mode_e m0,
                            input logic [15:0] c1, input mode_e m1);
    if (favor == 0) begin
      issue(0, c0, m0);
      issue(1, c1, m1);
    end else begin
      issue(1, c1, m1);
      issue(0, c0, m0);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (txn_q.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", txn_q.size(), 0);
  endtask

  function automatic logic [15:0] rand_code();
    logic [15:0] c;
    c = 16'($urandom());
    return ($urandom_range(0, 1) == 0) ? SECRET : c;
  endfunction

  // Requesters: hold req until done; keep it high if another code is queued.
  always @(negedge clk) begin
    if (!reset) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end else begin
      if (req0 && done0) begin
        if (pq0.size() > 0) code0 = pq0.pop_front();
        else req0 = 1'b0;
      end else if (!req0 && pq0.size() > 0) begin
        req0  = 1'b1;
        code0 = pq0.pop_front();
      end else if (req0 && lock_enter && txn_q.size() > 0 && txn_q[0].port == 0) begin
        code0 = 16'($urandom());
      end
      if (req1 && done1) begin
        if (pq1.size() > 0) code1 = pq1.pop_front();
        else req1 = 1'b0;
      end else if (!req1 && pq1.size() > 0) begin
        req1  = 1'b1;
        code1 = pq1.pop_front();
      end else if (req1 && lock_enter && txn_q.size() > 0 && txn_q[0].port == 1) begin
        code1 = 16'($urandom());
      end
    end
  end

  // Behavioural lock: collects four digits, then answers after a short random delay.
  int          ndig = 0;
  int          last_en = 0;
  int          last4 = 0;
  int          vdelay = -1;
  int          vhold = 0;
  logic [15:0] got = '0;
  mode_e       vmode = MNormal;
  bit          vok = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      ndig = 0;
      vdelay = -1;
      vhold = 0;
      lock_green = 1'b0;
      lock_red = 1'b0;
      lock_alarm = 1'b0;
    end else begin
      if (vhold > 0) begin
        vhold--;
        if (vhold == 0) begin
          lock_green = 1'b0;
          lock_red = 1'b0;
          lock_alarm = 1'b0;
        end
      end
      if (vdelay > 0) vdelay--;
      if (vdelay == 0) begin
        vdelay = -1;
        vhold = 2;
        case (vmode)
          MNormal: begin lock_green = vok; lock_red = !vok; end
          MAlarm:  lock_alarm = 1'b1;
          MBoth:   begin lock_green = 1'b1; lock_red = 1'b1; end
          default: vhold = 0;
        endcase
      end
      if (lock_enter) begin
        if (ndig > 0) check("digit_spacing", cyc - last_en, GAP + 1);
        got = {got[11:0], lock_digit};
        last_en = cyc;
        ndig++;
        if (ndig == 4) begin
          ndig = 0;
          last4 = cyc;
          if (txn_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_code: got %0h, expected no transaction", got);
          end else begin
            check("digits", got, txn_q[0].code);
            vmode = txn_q[0].mode;
            vok = (got == SECRET);
            vdelay = GAP + 1 + $urandom_range(0, 3);
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every done pulse.
  int chk_after = 0;
  int lo_len = 0;
  int lo_enters = 0;

  always @(negedge clk) begin
    if (!reset) begin
      chk_after = 0;
      lo_len = 0;
      lo_enters = 0;
    end else begin
      if (chk_after == 1) check("busy_after_done", busy, 0);
      else if (chk_after == 2) check("lockout_after_alarm", locked_out, 1);
      chk_after = 0;
      if (done0 && done1) begin
        tests++;
        fails++;
        $display("FAIL done_both: got done0=1 done1=1, expected one port");
      end else if (done0 || done1) begin
        int p;
        p = done1 ? 1 : 0;
        if (txn_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done on port %0d, expected none", p);
        end else begin
          txn_t t;
          t = txn_q.pop_front();
          check("done_port", p, t.port);
          check("pass", (p == 1) ? pass1 : pass0, exp_pass(t));
          check("busy_during_done", busy, 1);
          if (t.mode == MSilent) check("timeout_latency", cyc - last4, GAP + 1 + TMO);
          chk_after = (t.mode == MAlarm) ? 2 : 1;
        end
      end
      if (locked_out) begin
        lo_len++;
        if (lock_enter) lo_enters++;
      end else if (lo_len > 0) begin
        check("lockout_len", lo_len, LOCK);
        check("enter_in_lockout", lo_enters, 0);
        lo_len = 0;
        lo_enters = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n, f, e, enters;
    reset = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    code0 = '0;
    code1 = '0;
    lock_green = 1'b0;
    lock_red = 1'b0;
    lock_alarm = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done0", done0, 0);
    check("rst_pass0", pass0, 0);
    check("rst_done1", done1, 0);
    check("rst_pass1", pass1, 0);
    check("rst_digit", lock_digit, 0);
    check("rst_enter", lock_enter, 0);
    check("rst_busy", busy, 0);
    check("rst_locked_out", locked_out, 0);
    reset = 1'b1;

    // Both held from reset: grants alternate 0,1,0,1.
    @(posedge clk);
    issue_both(SECRET, MNormal, 16'($urandom()), MNormal);
    issue_both(16'($urandom()), MNormal, SECRET, MNormal);
    drain(500);

    issue(0, SECRET, MNormal);
    drain(200);
    issue(1, 16'h9999, MNormal);
    drain(200);
    issue(0, 16'($urandom()), MSilent);
    drain(200);
    issue(1, SECRET, MBoth);
    drain(200);

    // Alarm, then req0 pending across the lockout window.
    issue(0, 16'h4321, MAlarm);
    n = 0;
    while (!locked_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("lockout_entered", locked_out, 1);
    @(posedge clk);
    issue(0, SECRET, MNormal);
    n = 0;
    while (locked_out && n < LOCK + 50) begin
      @(negedge clk);
      n++;
    end
    f = cyc;
    n = 0;
    while (!lock_enter && n < 20) begin
      @(negedge clk);
      n++;
    end
    e = cyc;
    check("grant_after_lockout", e - f, 1);
    drain(200);

    // Reset while the third digit is on the bus.
    @(posedge clk);
    issue(0, 16'h5678, MNormal);
    enters = 0;
    n = 0;
    while (enters < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (lock_enter) enters++;
    end
    check("third_digit_seen", enters, 3);
    reset = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    #1;
    check("reset_enter", lock_enter, 0);
    check("reset_busy", busy, 0);
    txn_q.delete();
    pq0.delete();
    pq1.delete();
    favor = 0;
    grants_exp = 0;
    fails_exp = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    issue(0, SECRET, MNormal);
    drain(200);

    for (int i = 0; i < 24; i++) begin
      int    sel, mr;
      mode_e m0, m1;
      mr = $urandom_range(0, 3);
      m0 = (mr < 2) ? MNormal : ((mr == 2) ? MSilent : MBoth);
      mr = $urandom_range(0, 3);
      m1 = (mr < 2) ? MNormal : ((mr == 2) ? MSilent : MBoth);
      sel = $urandom_range(0, 2);
      if (sel == 2) issue_both(rand_code(), m0, rand_code(), m1);
      else issue(sel, rand_code(), m0);
      drain(300);
    end

`ifdef ARB_STATS_EN
    check("grant_count", grant_count, grants_exp);
    check("fail_count", fail_count, fails_exp);
`endif
    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
